change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Back-end actuator for the vending controller. It accepts one transaction per request, consisting of a buy flag and a 2-bit change code. It drives the product-vend motor, then pays the change as 10tk and 5tk coins through a drop/ack handshake with the coin hoppers. It also tracks coin inventory, flags transactions it cannot pay, and latches a fault on a hopper that never acknowledges.

Parameters:
CNT_W, 6, width of each coin inventory counter; saturates at 2**CNT_W-1
INIT5, 10, 5tk coin count loaded at reset
INIT10, 10, 10tk coin count loaded at reset
VEND_CYCLES, 4, cycles the vend output is held high
ACK_TIMEOUT, 15, cycles a drop may stay asserted without coin_ack before fault

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  transaction offered by vending controller
req_ready  out  1  high only in IDLE; accept = req_valid & req_ready
buy  in  1  dispense product for this transaction
chg  in  2  change code: 00=0tk, 01=5tk, 10=10tk, 11=15tk
vend  out  1  product motor enable
coin5_drop  out  1  request one 5tk coin from hopper
coin10_drop  out  1  request one 10tk coin from hopper
coin_ack  in  1  hopper confirms one coin released (shared by both hoppers)
refill5  in  1  +1 to 5tk count per cycle high
refill10  in  1  +1 to 10tk count per cycle high
cnt5  out  CNT_W  current 5tk inventory
cnt10  out  CNT_W  current 10tk inventory
done  out  1  one-cycle pulse at end of every accepted transaction
short_err  out  1  transaction rejected for insufficient coins; held until next accept
fault  out  1  hopper timeout; sticky until reset

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE; cnt5=INIT5; cnt10=INIT10.
  - vend, coin5_drop, coin10_drop, done, short_err, fault all 0.
  - req_ready=1 (it is decoded from the IDLE state).
- States: IDLE, VEND, DROP10, GAP10, DROP5, GAP5, DONE, FAULT.
- On accept in IDLE:
  - Latch buy and chg; clear short_err.
  - Plan the change in tk: amount=5*chg; n10=min(amount/10, cnt10); n5=(amount-10*n10)/5.
  - If n5>cnt5: set short_err=1 and go to DONE. No vend, no coins, counts unchanged.
  - Otherwise: go to VEND if buy=1, else go to the first coin phase.
- Coin phases run in the order 10tk then 5tk; a phase with zero coins planned is skipped.
- VEND: vend=1 for exactly VEND_CYCLES cycles, then the coin phases.
- DROPx:
  - coinX_drop held 1 until coin_ack is sampled 1.
  - On that edge: decrement that count, decrement the remaining-coin counter, go to GAPx.
- GAPx: drop=0 for at least one cycle and until coin_ack=0. Then return to DROPx if coins remain, else move to the next phase or DONE.
- Only one of coin5_drop, coin10_drop, vend is ever high at a time.
- Timeout:
  - A timer counts cycles in DROPx with coin_ack=0.
  - When it reaches ACK_TIMEOUT: go to FAULT, set fault=1, all drives 0, req_ready=0.
  - FAULT is left only by reset.
- DONE: done=1 for one cycle, then IDLE.
- Counter update each cycle: next = cnt + refill − decrement, saturating at 2**CNT_W-1. A simultaneous refill and decrement leaves the count unchanged. Underflow is impossible by construction.
- Inputs chg and buy are ignored when no accept occurs.
- coin_ack asserted in IDLE or VEND is ignored.

Decomposition:
- Shared package:
  - state encoding;
  - change-code constants R0=2'b00, R5=2'b01, R10=2'b10, R15=2'b11 (shared with the vending controller);
  - coin values 5 and 10.
- One sub-module, coin_inventory: a saturating up/down counter with refill and decrement inputs, instantiated twice (5tk and 10tk).

Test Plan:
- Default params; accept buy=1, chg=01; coin_ack pulses 2 cycles after drop -> vend high 4 cycles, one coin5_drop, cnt5=9, cnt10=10, done pulse, short_err=0.
- Accept buy=0, chg=11 -> no vend; one coin10_drop then one coin5_drop; cnt10=9, cnt5=9; done pulse.
- INIT10=0; accept buy=1, chg=10 -> vend 4 cycles, then two coin5_drop pulses each separated by a GAP; cnt5=8.
- INIT5=0, INIT10=0; accept buy=1, chg=01 -> short_err=1, vend never high, counts stay 0, done pulse, req_ready back to 1.
- Accept chg=01 with coin_ack tied 0 -> coin5_drop high 15 cycles, then fault=1, drop=0, req_ready=0; stays until reset pulse, after which cnt5=10.
- refill10 held 60 cycles from 10 -> cnt10 saturates at 63; refill5 high on the same cycle as a coin_ack decrement -> cnt5 unchanged.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM states, change codes,
// coin values and the change-planning helper.
package change_dispenser_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      VEND   = 3'd1,
      DROP10 = 3'd2,
      GAP10  = 3'd3,
      DROP5  = 3'd4,
      GAP5   = 3'd5,
      DONE   = 3'd6,
      FAULT  = 3'd7
   } state_t;

   // Change codes, shared with the vending controller
   localparam logic [1:0] R0  = 2'b00;
   localparam logic [1:0] R5  = 2'b01;
   localparam logic [1:0] R10 = 2'b10;
   localparam logic [1:0] R15 = 2'b11;

   localparam int unsigned COIN5  = 32'd5;
   localparam int unsigned COIN10 = 32'd10;

   typedef struct packed {
      logic [1:0] n10;
      logic [1:0] n5;
   } plan_t;

   // Prefer 10tk coins while any are in stock; the rest is paid in 5tk coins.
   function automatic plan_t plan_change(input logic [1:0] chg, input logic have10);
      plan_t       p;
      int unsigned amount;
      int unsigned n10;
      case (chg)
         R0:      amount = 32'd0;
         R5:      amount = COIN5;
         R10:     amount = COIN10;
         R15:     amount = COIN10 + COIN5;
         default: amount = 32'd0;
      endcase
      if (have10 && (amount >= COIN10)) begin
         n10 = 32'd1;
      end else begin
         n10 = 32'd0;
      end
      p.n10 = 2'(n10);
      p.n5  = 2'((amount - (COIN10 * n10)) / COIN5);
      return p;
   endfunction

endpackage

// File: rtl/change_dispenser_coin_inventory.sv
// Saturating coin inventory counter: +1 per refill cycle, -1 per released coin.
module coin_inventory
   import change_dispenser_pkg::*;
#(
   parameter int CNT_W = 6,
   parameter int INIT  = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             refill,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] MAX_CNT = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_n_s;

   // Next count; refill and decrement together cancel out
   always_comb begin
      cnt_n_s = cnt_r;
      if (refill && !dec) begin
         if (cnt_r != MAX_CNT) begin
            cnt_n_s = cnt_r + ONE;
         end else begin
            cnt_n_s = cnt_r;
         end
      end else if (dec && !refill) begin
         cnt_n_s = cnt_r - ONE;
      end else begin
         cnt_n_s = cnt_r;
      end
   end

   // Inventory register, loaded with the initial stock on reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_r <= CNT_W'(INIT);
      end else begin
         cnt_r <= cnt_n_s;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/change_dispenser.sv
// Vending back-end: runs the product motor, pays change through the coin
// hopper drop/ack handshake, tracks inventory and latches hopper faults.
module change_dispenser
   import change_dispenser_pkg::*;
#(
   parameter int CNT_W       = 6,
   parameter int INIT5       = 10,
   parameter int INIT10      = 10,
   parameter int VEND_CYCLES = 4,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             buy,
   input  logic [1:0]       chg,
   output logic             vend,
   output logic             coin5_drop,
   output logic             coin10_drop,
   input  logic             coin_ack,
   input  logic             refill5,
   input  logic             refill10,
   output logic [CNT_W-1:0] cnt5,
   output logic [CNT_W-1:0] cnt10,
   output logic             done,
   output logic             short_err,
   output logic             fault
);

   localparam int VC_W = $clog2(VEND_CYCLES + 1);
   localparam int TM_W = $clog2(ACK_TIMEOUT + 1);

   state_t           state_r;
   state_t           state_n_s;
   logic [1:0]       rem10_r;
   logic [1:0]       rem10_n_s;
   logic [1:0]       rem5_r;
   logic [1:0]       rem5_n_s;
   logic [VC_W-1:0]  vend_cnt_r;
   logic [VC_W-1:0]  vend_cnt_n_s;
   logic [TM_W-1:0]  timer_r;
   logic [TM_W-1:0]  timer_n_s;
   logic             short_err_r;
   logic             short_err_n_s;
   logic             dec5_s;
   logic             dec10_s;
   logic             accept_s;
   logic             short_s;
   plan_t            plan_s;
   logic [CNT_W-1:0] cnt5_s;
   logic [CNT_W-1:0] cnt10_s;

   logic             req_ready_r;
   logic             vend_r;
   logic             coin5_drop_r;
   logic             coin10_drop_r;
   logic             done_r;
   logic             fault_r;

   function automatic state_t next_phase(input logic [1:0] r10, input logic [1:0] r5);
      if (r10 != 2'd0) begin
         return DROP10;
      end else if (r5 != 2'd0) begin
         return DROP5;
      end else begin
         return DONE;
      end
   endfunction

   assign accept_s = req_valid && (state_r == IDLE);
   assign plan_s   = plan_change(chg, (cnt10_s != {CNT_W{1'b0}}));
   assign short_s  = (CNT_W'(plan_s.n5) > cnt5_s);

   // Next-state, coin bookkeeping and hopper timeout
   always_comb begin
      state_n_s     = state_r;
      rem10_n_s     = rem10_r;
      rem5_n_s      = rem5_r;
      vend_cnt_n_s  = vend_cnt_r;
      timer_n_s     = timer_r;
      short_err_n_s = short_err_r;
      dec5_s        = 1'b0;
      dec10_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               vend_cnt_n_s = {VC_W{1'b0}};
               timer_n_s    = {TM_W{1'b0}};
               if (short_s) begin
                  short_err_n_s = 1'b1;
                  rem10_n_s     = 2'd0;
                  rem5_n_s      = 2'd0;
                  state_n_s     = DONE;
               end else begin
                  short_err_n_s = 1'b0;
                  rem10_n_s     = plan_s.n10;
                  rem5_n_s      = plan_s.n5;
                  if (buy) begin
                     state_n_s = VEND;
                  end else begin
                     state_n_s = next_phase(plan_s.n10, plan_s.n5);
                  end
               end
            end else begin
               state_n_s = IDLE;
            end
         end
         VEND: begin
            if (vend_cnt_r == VC_W'(VEND_CYCLES - 1)) begin
               state_n_s = next_phase(rem10_r, rem5_r);
            end else begin
               vend_cnt_n_s = vend_cnt_r + VC_W'(1);
            end
         end
         DROP10: begin
            if (coin_ack) begin
               dec10_s   = 1'b1;
               rem10_n_s = rem10_r - 2'd1;
               timer_n_s = {TM_W{1'b0}};
               state_n_s = GAP10;
            end else if (timer_r == TM_W'(ACK_TIMEOUT - 1)) begin
               state_n_s = FAULT;
            end else begin
               timer_n_s = timer_r + TM_W'(1);
            end
         end
         GAP10: begin
            if (!coin_ack) begin
               state_n_s = next_phase(rem10_r, rem5_r);
            end else begin
               state_n_s = GAP10;
            end
         end
         DROP5: begin
            if (coin_ack) begin
               dec5_s    = 1'b1;
               rem5_n_s  = rem5_r - 2'd1;
               timer_n_s = {TM_W{1'b0}};
               state_n_s = GAP5;
            end else if (timer_r == TM_W'(ACK_TIMEOUT - 1)) begin
               state_n_s = FAULT;
            end else begin
               timer_n_s = timer_r + TM_W'(1);
            end
         end
         GAP5: begin
            if (!coin_ack) begin
               state_n_s = next_phase(rem10_r, rem5_r);
            end else begin
               state_n_s = GAP5;
            end
         end
         DONE:    state_n_s = IDLE;
         FAULT:   state_n_s = FAULT;
         default: state_n_s = FAULT;
      endcase
   end

   // State, bookkeeping and registered output drives
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r       <= IDLE;
         rem10_r       <= 2'd0;
         rem5_r        <= 2'd0;
         vend_cnt_r    <= {VC_W{1'b0}};
         timer_r       <= {TM_W{1'b0}};
         short_err_r   <= 1'b0;
         req_ready_r   <= 1'b1;
         vend_r        <= 1'b0;
         coin5_drop_r  <= 1'b0;
         coin10_drop_r <= 1'b0;
         done_r        <= 1'b0;
         fault_r       <= 1'b0;
      end else begin
         state_r       <= state_n_s;
         rem10_r       <= rem10_n_s;
         rem5_r        <= rem5_n_s;
         vend_cnt_r    <= vend_cnt_n_s;
         timer_r       <= timer_n_s;
         short_err_r   <= short_err_n_s;
         req_ready_r   <= (state_n_s == IDLE);
         vend_r        <= (state_n_s == VEND);
         coin5_drop_r  <= (state_n_s == DROP5);
         coin10_drop_r <= (state_n_s == DROP10);
         done_r        <= (state_n_s == DONE);
         fault_r       <= (state_n_s == FAULT);
      end
   end

   coin_inventory #(
      .CNT_W (CNT_W),
      .INIT  (INIT5)
   ) u_inv5 (
      .clock  (clock),
      .reset  (reset),
      .refill (refill5),
      .dec    (dec5_s),
      .cnt    (cnt5_s)
   );

   coin_inventory #(
      .CNT_W (CNT_W),
      .INIT  (INIT10)
   ) u_inv10 (
      .clock  (clock),
      .reset  (reset),
      .refill (refill10),
      .dec    (dec10_s),
      .cnt    (cnt10_s)
   );

   assign req_ready   = req_ready_r;
   assign vend        = vend_r;
   assign coin5_drop  = coin5_drop_r;
   assign coin10_drop = coin10_drop_r;
   assign done        = done_r;
   assign short_err   = short_err_r;
   assign fault       = fault_r;
   assign cnt5        = cnt5_s;
   assign cnt10       = cnt10_s;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus randomized
// transactions checked against a plain-arithmetic model of coins and inventory.
module tb_change_dispenser;

   localparam int CNT_W       = 6;
   localparam int INIT5       = 10;
   localparam int INIT10      = 10;
   localparam int VEND_CYCLES = 4;
   localparam int ACK_TIMEOUT = 15;
   localparam int CNT_MAX     = 63;

   logic             clock;
   logic             reset;
   logic             req_valid;
   logic             req_ready;
   logic             buy;
   logic [1:0]       chg;
   logic             vend;
   logic             coin5_drop;
   logic             coin10_drop;
   logic             coin_ack;
   logic             refill5;
   logic             refill10;
   logic [CNT_W-1:0] cnt5;
   logic [CNT_W-1:0] cnt10;
   logic             done;
   logic             short_err;
   logic             fault;

   int checks;
   int failures;
   int m5;
   int m10;

   change_dispenser #(
      .CNT_W       (CNT_W),
      .INIT5       (INIT5),
      .INIT10      (INIT10),
      .VEND_CYCLES (VEND_CYCLES),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .buy         (buy),
      .chg         (chg),
      .vend        (vend),
      .coin5_drop  (coin5_drop),
      .coin10_drop (coin10_drop),
      .coin_ack    (coin_ack),
      .refill5     (refill5),
      .refill10    (refill10),
      .cnt5        (cnt5),
      .cnt10       (cnt10),
      .done        (done),
      .short_err   (short_err),
      .fault       (fault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic assert_reset();
      @(negedge clock);
      reset     = 1'b0;
      req_valid = 1'b0;
      coin_ack  = 1'b0;
      refill5   = 1'b0;
      refill10  = 1'b0;
      #2;
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset = 1'b1;
      m5    = INIT5;
      m10   = INIT10;
   endtask

   // One transaction with a responsive hopper; compares everything to the model.
   task automatic do_txn(input string name, input logic b, input logic [1:0] c,
                         input int d, input bit rf);
      int amount, n10, n5, exp_v, exp10, exp5;
      int v_cnt, d10, d5, hi_cnt, cyc;
      bit sh, overlap, order_bad, got_done;
      logic p10, p5;
      amount = 5 * c;
      n10 = amount / 10;
      if (n10 > m10) n10 = m10;
      n5 = (amount - 10 * n10) / 5;
      sh = (n5 > m5);
      exp_v  = sh ? 0 : (b ? VEND_CYCLES : 0);
      exp10  = sh ? 0 : n10;
      exp5   = sh ? 0 : n5;
      cyc = 0;
      while (req_ready !== 1'b1 && cyc < 20) begin
         @(negedge clock);
         cyc++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s ready_wait got=%b exp=1", name, req_ready);
      end
      buy = b;
      chg = c;
      req_valid = 1'b1;
      @(negedge clock);
      req_valid = 1'b0;
      buy = 1'($urandom);
      chg = 2'($urandom);
      v_cnt = 0; d10 = 0; d5 = 0; hi_cnt = 0; cyc = 0;
      overlap = 0; order_bad = 0; got_done = 0;
      p10 = 1'b0; p5 = 1'b0;
      while (!got_done && cyc < 400) begin
         if ($countones({vend, coin5_drop, coin10_drop}) > 1) overlap = 1;
         if (vend === 1'b1) begin
            v_cnt++;
            if (d10 + d5 > 0) order_bad = 1;
         end
         if (coin10_drop === 1'b1 && !p10) begin
            d10++;
            if (d5 > 0) order_bad = 1;
         end
         if (coin5_drop === 1'b1 && !p5) d5++;
         if (done === 1'b1) got_done = 1;
         refill5 = 1'b0;
         if (coin10_drop === 1'b1 || coin5_drop === 1'b1) begin
            if (hi_cnt >= d) begin
               coin_ack = 1'b1;
               if (rf && coin5_drop === 1'b1) refill5 = 1'b1;
            end
            hi_cnt++;
         end else begin
            coin_ack = 1'b0;
            hi_cnt = 0;
         end
         p10 = coin10_drop;
         p5  = coin5_drop;
         if (!got_done) begin
            @(negedge clock);
            cyc++;
         end
      end
      coin_ack = 1'b0;
      refill5  = 1'b0;
      m10 = m10 - exp10;
      if (!rf) m5 = m5 - exp5;
      checks++;
      if (!got_done) begin
         failures++;
         $display("FAIL %s done_timeout got=0 exp=1", name);
      end
      checks++;
      if (v_cnt != exp_v) begin
         failures++;
         $display("FAIL %s vend_cycles got=%0d exp=%0d", name, v_cnt, exp_v);
      end
      checks++;
      if (d10 != exp10) begin
         failures++;
         $display("FAIL %s drops10 got=%0d exp=%0d", name, d10, exp10);
      end
      checks++;
      if (d5 != exp5) begin
         failures++;
         $display("FAIL %s drops5 got=%0d exp=%0d", name, d5, exp5);
      end
      checks++;
      if (overlap || order_bad) begin
         failures++;
         $display("FAIL %s sequencing got=overlap%0d/order%0d exp=0/0", name, overlap, order_bad);
      end
      checks++;
      if (short_err !== sh) begin
         failures++;
         $display("FAIL %s short_err got=%b exp=%b", name, short_err, sh);
      end
      @(negedge clock);
      checks++;
      if (cnt5 !== CNT_W'(m5) || cnt10 !== CNT_W'(m10)) begin
         failures++;
         $display("FAIL %s counts got=%0d/%0d exp=%0d/%0d", name, cnt5, cnt10, m5, m10);
      end
      checks++;
      if (done !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s after_done got=done%b/ready%b exp=0/1", name, done, req_ready);
      end
   endtask

   task automatic idle_refill(input int cycles);
      bit r5, r10;
      for (int i = 0; i < cycles; i++) begin
         r5  = 1'($urandom);
         r10 = 1'($urandom);
         refill5  = r5;
         refill10 = r10;
         @(negedge clock);
         if (r5 && m5 < CNT_MAX) m5++;
         if (r10 && m10 < CNT_MAX) m10++;
      end
      refill5  = 1'b0;
      refill10 = 1'b0;
   endtask

   task automatic test_reset();
      assert_reset();
      checks++;
      if (cnt5 !== CNT_W'(INIT5) || cnt10 !== CNT_W'(INIT10)) begin
         failures++;
         $display("FAIL reset_counts got=%0d/%0d exp=%0d/%0d", cnt5, cnt10, INIT5, INIT10);
      end
      checks++;
      if ({vend, coin5_drop, coin10_drop, done, short_err, fault} !== 6'b000000) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=000000",
                  {vend, coin5_drop, coin10_drop, done, short_err, fault});
      end
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%b exp=1", req_ready);
      end
      release_reset();
   endtask

   task automatic test_ignore_idle();
      for (int i = 0; i < 4; i++) begin
         coin_ack = 1'b1;
         buy = 1'($urandom);
         chg = 2'($urandom);
         @(negedge clock);
         checks++;
         if (req_ready !== 1'b1 || vend !== 1'b0 || coin5_drop !== 1'b0 || coin10_drop !== 1'b0
             || cnt5 !== CNT_W'(m5) || cnt10 !== CNT_W'(m10)) begin
            failures++;
            $display("FAIL idle_ack_ignored got=ready%b cnt%0d/%0d exp=ready1 cnt%0d/%0d",
                     req_ready, cnt5, cnt10, m5, m10);
         end
      end
      coin_ack = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_no_tens();
      while (m10 > 0) do_txn("drain10", 1'b0, 2'b10, $urandom_range(0, 3), 1'b0);
      do_txn("buy10_no_tens", 1'b1, 2'b10, 2, 1'b0);
      do_txn("chg15_no_tens", 1'b0, 2'b11, 1, 1'b0);
   endtask

   task automatic test_short();
      while (m5 >= 3) do_txn("drain5", 1'b0, 2'b11, 0, 1'b0);
      while (m5 > 0) do_txn("drain5b", 1'b0, 2'b01, 0, 1'b0);
      do_txn("short_buy5", 1'b1, 2'b01, 2, 1'b0);
      repeat (3) @(negedge clock);
      checks++;
      if (short_err !== 1'b1) begin
         failures++;
         $display("FAIL short_held got=%b exp=1", short_err);
      end
      do_txn("zero_change", 1'b1, 2'b00, 2, 1'b0);
      do_txn("short_chg10", 1'b0, 2'b10, 2, 1'b0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 40; t++) begin
         idle_refill($urandom_range(0, 6));
         do_txn("random", 1'($urandom), 2'($urandom), $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
      end
   endtask

   task automatic test_saturate();
      assert_reset();
      release_reset();
      refill10 = 1'b1;
      repeat (60) begin
         @(negedge clock);
         if (m10 < CNT_MAX) m10++;
      end
      refill10 = 1'b0;
      checks++;
      if (cnt10 !== CNT_W'(m10) || m10 != CNT_MAX) begin
         failures++;
         $display("FAIL saturate10 got=%0d exp=%0d", cnt10, CNT_MAX);
      end
      do_txn("refill_with_ack", 1'b0, 2'b01, 2, 1'b1);
   endtask

   task automatic test_fault();
      int hi, cyc;
      bit bad;
      assert_reset();
      release_reset();
      @(negedge clock);
      buy = 1'b0;
      chg = 2'b01;
      req_valid = 1'b1;
      @(negedge clock);
      req_valid = 1'b0;
      hi = 0;
      cyc = 0;
      while (fault !== 1'b1 && cyc < 100) begin
         if (coin5_drop === 1'b1) hi++;
         @(negedge clock);
         cyc++;
      end
      checks++;
      if (hi != ACK_TIMEOUT) begin
         failures++;
         $display("FAIL fault_drop_cycles got=%0d exp=%0d", hi, ACK_TIMEOUT);
      end
      checks++;
      if (fault !== 1'b1 || coin5_drop !== 1'b0 || req_ready !== 1'b0 || vend !== 1'b0) begin
         failures++;
         $display("FAIL fault_entry got=fault%b drop%b ready%b exp=1/0/0", fault, coin5_drop, req_ready);
      end
      bad = 0;
      req_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         coin_ack = 1'(i % 2);
         @(negedge clock);
         if (fault !== 1'b1 || req_ready !== 1'b0 || coin5_drop !== 1'b0 || coin10_drop !== 1'b0
             || vend !== 1'b0 || cnt5 !== CNT_W'(INIT5)) bad = 1;
      end
      req_valid = 1'b0;
      coin_ack  = 1'b0;
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL fault_sticky got=left_fault exp=held");
      end
      assert_reset();
      release_reset();
      @(negedge clock);
      checks++;
      if (fault !== 1'b0 || req_ready !== 1'b1 || cnt5 !== CNT_W'(INIT5)) begin
         failures++;
         $display("FAIL fault_cleared got=fault%b ready%b cnt5=%0d exp=0/1/%0d",
                  fault, req_ready, cnt5, INIT5);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b0;
      req_valid = 1'b0;
      buy       = 1'b0;
      chg       = 2'b00;
      coin_ack  = 1'b0;
      refill5   = 1'b0;
      refill10  = 1'b0;
      m5        = INIT5;
      m10       = INIT10;
      test_reset();
      do_txn("buy_chg5", 1'b1, 2'b01, 2, 1'b0);
      do_txn("nobuy_chg15", 1'b0, 2'b11, 2, 1'b0);
      test_ignore_idle();
      test_no_tens();
      test_short();
      test_random();
      test_saturate();
      test_fault();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
